// File: rtl/ps2_scan_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_scan_ctrl
//
// Turns the raw byte stream of a PS/2 receiver into decoded key events and
// buffers them for the CPU in a first-word-fall-through event FIFO.
//
// The scanner tracks the E0 (extended) and F0 (break) prefixes. Receiver
// errors, keyboard overrun codes (00/FF), illegal prefix orders and stalled
// prefixes drop the sequence back to IDLE and raise a one-cycle seq_err.
//
// Parameters
//   DEPTH           event FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  clk cycles allowed in a prefix state before abandoning it
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   enable       1 = accept bytes; 0 = ignore byte_valid, force FSM to IDLE
//   byte_valid   one-cycle strobe: byte_data / byte_err valid
//   byte_data    received scan byte
//   byte_err     receiver parity/framing error, qualified by byte_valid
//   evt_valid    FIFO non-empty, head presented on evt_*
//   evt_ready    pop request; head removed when evt_valid & evt_ready
//   evt_code     head event scan code (0 while empty)
//   evt_ext      head event carried an E0 prefix
//   evt_brk      head event carried an F0 prefix (key release)
//   fifo_count   occupied FIFO entries, 0..DEPTH
//   seq_err      one-cycle pulse on any sequence error or timeout
//   overflow     sticky: an event was dropped because the FIFO was full
//   ovf_clr      clears overflow; a new overflow in the same cycle wins
// -----------------------------------------------------------------------------
module ps2_scan_ctrl #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    input  logic                     byte_err,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_brk,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     seq_err,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_E0,
        ST_GOT_F0,
        ST_GOT_E0F0
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    // -------------------------------------------------------------------------
    // Scan-sequence FSM
    // -------------------------------------------------------------------------
    state_t          state, state_next;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_next;
    logic            err_next;
    logic            emit;
    logic            emit_ext;
    logic            emit_brk;
    logic            byte_acc;
    logic            is_prefix;
    logic            is_overrun;

    assign byte_acc   = enable & byte_valid;
    assign is_prefix  = (byte_data == CODE_E0) || (byte_data == CODE_F0);
    assign is_overrun = (byte_data == 8'h00) || (byte_data == 8'hFF);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the if/case tree leaves a variable unassigned (no latches).
        state_next = state;
        err_next   = 1'b0;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;

        if (!enable) begin
            // Dropping enable abandons a prefix silently.
            state_next = ST_IDLE;
        end else if (byte_acc) begin
            if (byte_err || is_overrun) begin
                state_next = ST_IDLE;
                err_next   = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (byte_data == CODE_E0) begin
                            state_next = ST_GOT_E0;
                        end else if (byte_data == CODE_F0) begin
                            state_next = ST_GOT_F0;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    ST_GOT_E0: begin
                        // A repeated E0 is tolerated and keeps the state.
                        if (byte_data == CODE_F0) begin
                            state_next = ST_GOT_E0F0;
                        end else if (byte_data != CODE_E0) begin
                            emit       = 1'b1;
                            emit_ext   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    ST_GOT_F0, ST_GOT_E0F0: begin
                        // After F0 only a plain scan code is legal.
                        state_next = ST_IDLE;
                        if (is_prefix) begin
                            err_next = 1'b1;
                        end else begin
                            emit     = 1'b1;
                            emit_ext = (state == ST_GOT_E0F0);
                            emit_brk = 1'b1;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end else if (state != ST_IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // Stalled prefix; an arriving byte would have taken the branch above.
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end

        // Counter only runs while a prefix is pending and restarts on each byte.
        if (byte_acc || state_next == ST_IDLE) begin
            tmo_cnt_next = '0;
        end else begin
            tmo_cnt_next = tmo_cnt + TW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // -------------------------------------------------------------------------
    evt_t            mem [DEPTH];
    evt_t            head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty, fifo_full;
    logic            push, pop, drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign pop        = ~fifo_empty & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = emit & (~fifo_full | pop);
    assign drop       = emit & fifo_full & ~pop;

    // NOTE: the storage array carries no reset; the occupancy count alone
    // says which entries are meaningful, and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{code: byte_data, ext: emit_ext, brk: emit_brk};
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            seq_err  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
            seq_err <= err_next;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = ~fifo_empty;
    assign evt_code   = fifo_empty ? 8'h00 : head.code;
    assign evt_ext    = fifo_empty ? 1'b0  : head.ext;
    assign evt_brk    = fifo_empty ? 1'b0  : head.brk;
    assign fifo_count = count;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_scan_ctrl
//
// Directed stimulus against ps2_scan_ctrl (DEPTH=4, TIMEOUT_CYCLES=16).
// A behavioural model built from prefix flags, an age counter and a queue
// predicts every output each cycle; literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_ps2_scan_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic [2:0] fifo_count;
    logic       seq_err;
    logic       overflow;
    logic       ovf_clr;

    always #5 clk = ~clk;

    ps2_scan_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .fifo_count (fifo_count),
        .seq_err    (seq_err),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    ev_t mq[$];
    bit  m_err, m_ovf;
    bit  pend_ext, pend_brk, in_seq;
    int  age;
    bit  checking = 1'b0;

    function automatic void clear_seq();
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        in_seq   = 1'b0;
        age      = 0;
    endfunction

    // Applies one clock edge's worth of behaviour using the inputs at the edge.
    function automatic void model_update();
        ev_t e;
        bit  emit = 1'b0;
        bit  err  = 1'b0;
        bit  popq, was_full;
        e = '0;
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
            clear_seq();
            checking = 1'b1;
            return;
        end
        if (!enable) begin
            clear_seq();
        end else if (byte_valid) begin
            if (byte_err || byte_data == 8'h00 || byte_data == 8'hFF) begin
                err = 1'b1;
                clear_seq();
            end else if (byte_data == 8'hE0 || byte_data == 8'hF0) begin
                if (pend_brk) begin
                    err = 1'b1;
                    clear_seq();
                end else begin
                    in_seq = 1'b1;
                    age    = 0;
                    if (byte_data == 8'hE0) pend_ext = 1'b1;
                    else                    pend_brk = 1'b1;
                end
            end else begin
                emit = 1'b1;
                e    = {byte_data, pend_ext, pend_brk};
                clear_seq();
            end
        end else if (in_seq) begin
            if (age == TMO - 1) begin
                err = 1'b1;
                clear_seq();
            end else begin
                age++;
            end
        end
        m_err    = err;
        popq     = (mq.size() != 0) && evt_ready;
        was_full = (mq.size() == DEPTH);
        if (popq) void'(mq.pop_front());
        if (emit) begin
            if (!was_full || popq) mq.push_back(e);
            else                   m_ovf = 1'b1;
        end
        if (ovf_clr && !(emit && was_full && !popq)) m_ovf = 1'b0;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (checking) begin
            check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("seq_err", 32'(seq_err), 32'(m_err));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (mq.size() != 0)
                check("head", 32'({evt_code, evt_ext, evt_brk}), 32'(mq[0]));
            else
                check("empty_head", 32'({evt_code, evt_ext, evt_brk}), 32'(0));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_err   = err;
        step();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_err   = 1'b0;
    endtask

    task automatic expect_pop(input string name, input logic [7:0] code,
                              input logic ext, input logic brk);
        check(name, 32'({evt_valid, evt_code, evt_ext, evt_brk}), 32'({1'b1, code, ext, brk}));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    int err_at;
    int n_pulses;

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_err   = 1'b0;
        evt_ready  = 1'b0;
        ovf_clr    = 1'b0;
        step();
        rst = 1'b0;
        check("reset_count", 32'(fifo_count), 32'(0));
        check("reset_flags", 32'({evt_valid, seq_err, overflow}), 32'(0));

        // Make and break of the same key.
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        check("two_events_count", 32'(fifo_count), 32'(2));
        expect_pop("make_1c", 8'h1C, 1'b0, 1'b0);
        expect_pop("break_1c", 8'h1C, 1'b0, 1'b1);
        check("drained", 32'(fifo_count), 32'(0));

        // Extended make, extended break, duplicated E0.
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'hE0); send(8'h6B);
        check("ext_count", 32'(fifo_count), 32'(3));
        expect_pop("ext_make_75", 8'h75, 1'b1, 1'b0);
        expect_pop("ext_break_75", 8'h75, 1'b1, 1'b1);
        expect_pop("dup_e0_6b", 8'h6B, 1'b1, 1'b0);

        // Receiver error after F0, then a clean make.
        send(8'hF0);
        send(8'h55, 1'b1);
        check("byte_err_pulse", 32'(seq_err), 32'(1));
        send(8'h1C);
        check("byte_err_pulse_width", 32'(seq_err), 32'(0));
        expect_pop("after_err_1c", 8'h1C, 1'b0, 1'b0);

        // F0 F0 is a protocol error.
        send(8'hF0);
        send(8'hF0);
        check("f0f0_pulse", 32'(seq_err), 32'(1));
        send(8'h1C);
        expect_pop("after_f0f0_1c", 8'h1C, 1'b0, 1'b0);

        // Stalled prefix times out after TMO cycles in GOT_E0.
        send(8'hE0);
        err_at   = -1;
        n_pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (seq_err) begin
                err_at = k;
                n_pulses++;
            end
        end
        check("timeout_cycle", 32'(err_at), 32'(16));
        check("timeout_pulses", 32'(n_pulses), 32'(1));
        send(8'h1C);
        expect_pop("after_timeout_1c", 8'h1C, 1'b0, 1'b0);

        // A byte well inside the window, and one on the last cycle.
        send(8'hE0); idle(9);  send(8'h1C);
        expect_pop("e0_10cyc", 8'h1C, 1'b1, 1'b0);
        send(8'hE0); idle(15); send(8'h74);
        expect_pop("e0_byte_wins", 8'h74, 1'b1, 1'b0);

        // Overflow, clear, push-with-pop while full, set beats clear.
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("full_count", 32'(fifo_count), 32'(4));
        check("overflow_set", 32'(overflow), 32'(1));
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("overflow_clr", 32'(overflow), 32'(0));
        evt_ready = 1'b1;
        send(8'h06);
        evt_ready = 1'b0;
        check("full_push_pop_count", 32'(fifo_count), 32'(4));
        ovf_clr = 1'b1;
        send(8'h07);
        ovf_clr = 1'b0;
        check("set_wins_clr", 32'(overflow), 32'(1));
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        expect_pop("fifo_02", 8'h02, 1'b0, 1'b0);
        expect_pop("fifo_03", 8'h03, 1'b0, 1'b0);
        expect_pop("fifo_04", 8'h04, 1'b0, 1'b0);
        expect_pop("fifo_tail_06", 8'h06, 1'b0, 1'b0);

        // Reset in the middle of a sequence discards the prefix.
        send(8'hE0);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_reset_empty", 32'(fifo_count), 32'(0));
        send(8'h1C);
        expect_pop("after_reset_1c", 8'h1C, 1'b0, 1'b0);

        // Overrun code inside GOT_F0.
        send(8'hF0);
        send(8'h00);
        check("overrun_pulse", 32'(seq_err), 32'(1));
        check("overrun_no_event", 32'(fifo_count), 32'(0));

        // Enable drop abandons prefix silently and ignores bytes.
        send(8'hE0);
        enable = 1'b0;
        step();
        send(8'h2A);
        enable = 1'b1;
        send(8'h1C);
        check("enable_drop_count", 32'(fifo_count), 32'(1));
        expect_pop("enable_drop_1c", 8'h1C, 1'b0, 1'b0);

        // Pop request on an empty FIFO coinciding with a push.
        evt_ready = 1'b1;
        send(8'h33);
        evt_ready = 1'b0;
        check("empty_push_pop", 32'(fifo_count), 32'(1));
        expect_pop("empty_push_33", 8'h33, 1'b0, 1'b0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
